// File: rtl/axi_read_responder.sv
// AXI4 read-only responder backed by a word array with a preload port.
// First beat appears LATENCY cycles after AR acceptance; errors never shorten a burst.
module axi_read_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  input  logic        i_axi_rready,
  output logic [1:0]  o_axi_rresp,
  output logic [3:0]  o_axi_rid,
  output logic        o_axi_rlast,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;
  logic        slv_q, slv_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  lat_q, lat_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        rlast_q, rlast_d;

  logic [31:0] mem_q [DEPTH];

  logic        ld;
  logic [31:0] ld_addr;
  logic        ld_slv;
  logic        ld_last;
  logic        ld_ok;
  logic        in_slv;
  logic [31:0] nxt;

  function automatic logic in_range(input logic [31:0] a);
    return (a - BASE) < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] next_addr(
    input logic [31:0] a,
    input logic [1:0]  burst,
    input logic [7:0]  len
  );
    logic [31:0] mask;
    mask = {22'd0, len, 2'b11};
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + 32'd4) & mask);
      default: return a + 32'd4;
    endcase
  endfunction

  assign in_slv = (i_axi_arsize != 3'b010)
               || (i_axi_araddr[1:0] != 2'b00)
               || (i_axi_arburst == 2'b11)
               || ((i_axi_arburst == 2'b10)
                   && !(i_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  assign nxt = next_addr(addr_q, burst_q, len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    id_d    = id_q;
    slv_d   = slv_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rlast_d = rlast_q;
    ld      = 1'b0;
    ld_addr = addr_q;
    ld_slv  = slv_q;
    ld_last = 1'b0;
    ld_ok   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_axi_arvalid) begin
          addr_d  = i_axi_araddr;
          len_d   = i_axi_arlen;
          burst_d = i_axi_arburst;
          id_d    = i_axi_arid;
          slv_d   = in_slv;
          cnt_d   = 8'd0;
          lat_d   = 4'd0;
          if (LATENCY == 0) begin
            state_d = S_BEAT;
            ld      = 1'b1;
            ld_addr = i_axi_araddr;
            ld_slv  = in_slv;
            ld_last = (i_axi_arlen == 8'd0);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 4'(LATENCY - 1)) begin
          state_d = S_BEAT;
          ld      = 1'b1;
          ld_last = (len_q == 8'd0);
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_BEAT: begin
        if (i_axi_rready) begin
          if (rlast_q) begin
            state_d = S_IDLE;
            rlast_d = 1'b0;
          end else begin
            addr_d  = nxt;
            cnt_d   = cnt_q + 8'd1;
            ld      = 1'b1;
            ld_addr = nxt;
            ld_last = (8'(cnt_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Beat data is captured from the array before any same-edge preload lands
    if (ld) begin
      ld_ok   = in_range(ld_addr);
      rlast_d = ld_last;
      rresp_d = ld_slv ? 2'b10 : (ld_ok ? 2'b00 : 2'b11);
      rdata_d = (ld_slv || !ld_ok) ? 32'd0 : mem_q[widx(ld_addr)];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      len_q   <= 8'd0;
      burst_q <= 2'b00;
      id_q    <= 4'd0;
      slv_q   <= 1'b0;
      cnt_q   <= 8'd0;
      lat_q   <= 4'd0;
      rdata_q <= 32'd0;
      rresp_q <= 2'b00;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rlast_q <= rlast_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_wr_en && in_range(i_wr_addr)) begin
      mem_q[widx(i_wr_addr)] <= i_wr_data;
    end
  end

  assign o_axi_arready = (state_q == S_IDLE) && !i_reset;
  assign o_axi_rvalid  = (state_q == S_BEAT);
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = rresp_q;
  assign o_axi_rid     = id_q;
  assign o_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder.
// Expected beats come from a reference memory and burst model.
module tb_axi_read_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          LAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic [3:0]  id;
    logic        l;
  } beat_t;

  beat_t       sb[$];
  bit   [31:0] mdl [1024];
  int          n_chk = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          rmode = 0;
  int          tog = 0;
  bit          held = 0;
  bit          post_last = 0;
  logic [31:0] h_d;
  logic [1:0]  h_r;
  logic        h_l;
  logic [3:0]  h_id;

  always #5 clk = ~clk;

  axi_read_responder #(
    .BASE(BASE), .DEPTH(1024), .LATENCY(LAT)
  ) dut (
    .i_clock(clk), .i_reset(rst),
    .i_axi_araddr(araddr), .i_axi_arvalid(arvalid),
    .o_axi_arready(arready), .i_axi_arid(arid),
    .i_axi_arlen(arlen), .i_axi_arsize(arsize),
    .i_axi_arburst(arburst), .o_axi_rdata(rdata),
    .o_axi_rvalid(rvalid), .i_axi_rready(rready),
    .o_axi_rresp(rresp), .o_axi_rid(rid),
    .o_axi_rlast(rlast), .i_wr_en(wr_en),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // rready: 0 = always, 1 = pattern 1,0,0,..., 2 = never
  always @(posedge clk) begin
    #1;
    tog = tog + 1;
    case (rmode)
      0:       rready = 1'b1;
      1:       rready = (tog % 3 == 0);
      default: rready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      held = 0;
      post_last = 0;
    end else begin
      if (post_last) begin
        chk("arready_ret", {31'd0, arready}, 1);
        chk("rvalid_off", {31'd0, rvalid}, 0);
        post_last = 0;
      end
      if (rvalid) begin
        chk("arready_busy", {31'd0, arready}, 0);
        if (held) begin
          chk("hold_data", rdata, h_d);
          chk("hold_resp", {30'd0, rresp}, {30'd0, h_r});
          chk("hold_last", {31'd0, rlast}, {31'd0, h_l});
          chk("hold_id", {28'd0, rid}, {28'd0, h_id});
        end
        if (rready) begin
          held = 0;
          hs_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("rdata", rdata, e.d);
            chk("rresp", {30'd0, rresp}, {30'd0, e.r});
            chk("rid", {28'd0, rid}, {28'd0, e.id});
            chk("rlast", {31'd0, rlast}, {31'd0, e.l});
          end
          if (rlast) post_last = 1;
        end else begin
          held = 1;
          h_d = rdata;
          h_r = rresp;
          h_l = rlast;
          h_id = rid;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if ((a - BASE) < 32'd4096) mdl[(a - BASE) >> 2] = d;
  endtask

  task automatic model(input logic [31:0] a0, input logic [7:0] len,
                       input logic [1:0] bu, input logic [2:0] sz,
                       input logic [3:0] id);
    bit          slv;
    logic [31:0] a;
    logic [31:0] span;
    logic [31:0] wb;
    beat_t       e;
    slv = (sz != 3'd2) || (a0[1:0] != 0) || (bu == 2'b11) ||
          (bu == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
    a = a0;
    span = (32'(len) + 1) * 4;
    for (int b = 0; b <= int'(len); b++) begin
      e.id = id;
      e.l = (b == int'(len));
      if (slv) begin
        e.r = 2'b10; e.d = 0;
      end else if ((a - BASE) >= 32'd4096) begin
        e.r = 2'b11; e.d = 0;
      end else begin
        e.r = 2'b00; e.d = mdl[(a - BASE) >> 2];
      end
      sb.push_back(e);
      if (bu == 2'b01) a = a + 4;
      else if (bu == 2'b10) begin
        wb = a - (a % span);
        a = wb + ((a + 4 - wb) % span);
      end
    end
  endtask

  task automatic ar(input logic [31:0] a, input logic [7:0] len,
                    input logic [1:0] bu, input logic [2:0] sz,
                    input logic [3:0] id);
    int n;
    bit ok;
    hs_cnt = 0;
    model(a, len, bu, sz, id);
    @(posedge clk); #1;
    araddr = a; arlen = len; arburst = bu;
    arsize = sz; arid = id; arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (arready) ok = 1;
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) ok = 1;
      else n++;
    end
    chk("first_latency", n, LAT);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rvalid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; arvalid = 0; araddr = 0; arid = 0; arlen = 0;
    arsize = 3'd2; arburst = 2'b01; rready = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", {30'd0, rresp}, 0);
    chk("rst_rid", {28'd0, rid}, 0);
    chk("rst_rlast", {31'd0, rlast}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_arready", {31'd0, arready}, 1);

    preload(BASE + 0, 32'h11);
    preload(BASE + 4, 32'h22);
    preload(BASE + 8, 32'h33);
    preload(BASE + 12, 32'h44);
    preload(BASE + 32'hFF8, 32'hAAAA_0FF8);
    preload(BASE + 32'hFFC, 32'hBBBB_0FFC);

    ar(BASE, 8'd3, 2'b01, 3'd2, 4'd1);
    drain();
    chk("incr_hs", hs_cnt, 4);
    ar(BASE + 4, 8'd1, 2'b10, 3'd2, 4'd5);
    drain();
    ar(BASE + 12, 8'd1, 2'b10, 3'd2, 4'd6);
    drain();
    rmode = 1;
    ar(BASE, 8'd3, 2'b01, 3'd2, 4'd2);
    drain();
    chk("stall_hs", hs_cnt, 4);
    rmode = 0;
    ar(BASE + 1, 8'd0, 2'b01, 3'd2, 4'd3);
    drain();
    ar(32'h7FFF_FFFC, 8'd1, 2'b01, 3'd2, 4'd4);
    drain();
    ar(BASE + 32'hFF8, 8'd2, 2'b01, 3'd2, 4'd7);
    drain();
    ar(BASE + 8, 8'd2, 2'b00, 3'd2, 4'd8);
    drain();
    ar(BASE, 8'd1, 2'b01, 3'd0, 4'd9);
    drain();
    ar(BASE, 8'd1, 2'b11, 3'd2, 4'd10);
    drain();
    ar(BASE, 8'd2, 2'b10, 3'd2, 4'd11);
    drain();

    ar(BASE, 8'd3, 2'b01, 3'd2, 4'd12);
    for (int i = 0; i < 50 && hs_cnt < 1; i++) @(negedge clk);
    rmode = 2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_rvalid", {31'd0, rvalid}, 0);
    chk("midrst_arready", {31'd0, arready}, 1);
    chk("midrst_rlast", {31'd0, rlast}, 0);
    rmode = 0;
    ar(BASE + 12, 8'd0, 2'b01, 3'd2, 4'd13);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
Name: axi_read_responder

Overview:
- AXI4 read-channel responder (slave), the memory-side counterpart of the instruction-cache AXI read initiator.
- Serves single and burst reads from an internal word array, with a programmable first-beat latency.
- Models MROM/SRAM/flash targets in the NPC simulation and SoC-lite builds.
- Provides a side preload write port for images and benches; there is no AXI write channel.

Parameters:
- BASE, 32'h80000000, byte address of word 0.
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, idle cycles between AR acceptance and the first rvalid (0..15).

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_axi_araddr  in  32  read address
- i_axi_arvalid  in  1  AR valid
- o_axi_arready  out  1  AR ready
- i_axi_arid  in  4  transaction id
- i_axi_arlen  in  8  beats minus 1
- i_axi_arsize  in  3  beat size; only 3'b010 is supported
- i_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- o_axi_rdata  out  32  read data
- o_axi_rvalid  out  1  R valid
- i_axi_rready  in  1  R ready
- o_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- o_axi_rid  out  4  echoed arid
- o_axi_rlast  out  1  last beat
- i_wr_en  in  1  preload write enable
- i_wr_addr  in  32  preload byte address (word-aligned; bits[1:0] ignored)
- i_wr_data  in  32  preload data

Behaviour:
- Reset: state IDLE, o_axi_arready=0 during the reset cycle, then 1. o_axi_rvalid=0, o_axi_rlast=0, o_axi_rresp=0, o_axi_rid=0, o_axi_rdata=0. Array contents are not cleared.
- Reset mid-burst: the burst is abandoned and all outputs take their reset values on the next edge.
- FSM states:
  - IDLE: arready=1. On arvalid&&arready, latch araddr, arid, arlen, arburst, and the error status; beat counter=0. Go to WAIT if LATENCY>0, else go to BEAT.
  - WAIT: arready=0; count LATENCY cycles, then go to BEAT.
  - BEAT: rvalid=1, arready=0.
    - On rvalid&&rready with beats remaining: advance the address, increment the counter, and present the next beat on the following cycle. rvalid stays 1.
    - On rvalid&&rready when rlast=1: go to IDLE. arready returns the cycle after the last handshake; no AR is accepted in the same cycle as the last R handshake.
- Timing: AR handshake at edge k gives first rvalid in cycle k+1+LATENCY.
- While rvalid=1 && !rready, rdata, rresp, rid and rlast are held stable.
- Beat addresses (4-byte beats):
  - FIXED: every beat uses araddr.
  - INCR: addr+4 per beat.
  - WRAP: span = (arlen+1)*4; next = (addr & ~(span-1)) | ((addr+4) & (span-1)). Example: arlen=1, addr 0x..0C, then 0x..08.
- Word index = (addr-BASE)>>2, truncated to log2(DEPTH) bits after the range check.
- Errors: every beat of the burst still completes and the count is unchanged. rdata=0 on any error beat. rid is echoed.
  - SLVERR on all beats: arsize!=3'b010, araddr[1:0]!=0, arburst==2'b11, or WRAP with arlen not in {1,3,7,15}.
  - DECERR per beat: beat address outside [BASE, BASE+4*DEPTH). INCR bursts crossing the top give OKAY then DECERR beats.
  - SLVERR takes priority over DECERR.
- rlast=1 exactly on beat arlen.
- Preload: when i_wr_en=1 and the address is in range, the word is written at the clock edge. Out-of-range writes are dropped.
  - Write-read collision: a write in the same cycle a beat is loaded returns the old word; later beats see the new word.
  - Preload is allowed in any state.
- Counters and widths: latency counter 4 bits; beat counter 8 bits; address arithmetic 32 bits, wrapping modulo 2^32.

Test Plan:
- Preload 0x80000000..0x8000000C with 0x11,0x22,0x33,0x44; INCR arlen=3 @0x80000000, rready=1, LATENCY=2 -> AR accepted at edge k, then rvalid in cycles k+3..k+6 with data 11,22,33,44, rresp=00, rlast only on 0x44, arready back in cycle k+7.
- WRAP arlen=1 @0x80000004, arid=5 -> beats 0x22 then 0x11, rid=5 both beats, rlast on the second beat.
- Same INCR burst with rready toggling 1,0,0,1,... -> each beat's rdata, rresp and rlast are held while stalled; exactly 4 handshakes total.
- Read @0x80000001 with arlen=0 -> one beat, rresp=10, rdata=0, rlast=1. Read @0x7FFFFFFC with INCR arlen=1 -> rresp 11 then OKAY with data 0x11.
- INCR arlen=2 @0x80000FF8 (DEPTH=1024) -> beat rresp values 00, 00, 11.
- Assert i_reset for one cycle during beat 2 of a 4-beat burst -> rvalid=0 next cycle, arready=1 the cycle after reset deasserts, and a following single read returns correct data.
